// File: rtl/inv_mix_col_seq_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | inv_mix_col_seq_if : start/busy/done bus for the InvMixColumns unit |
// | Revision 1.0                                                       |
// +------------------------------------------------------------------+
interface inv_mix_col_seq_if;
  logic         start;
  logic [127:0] data_in;
  logic [3:0]   count_out;
  logic         busy;
  logic         done;
  logic [127:0] data_out;

  modport master (
    output start, data_in, count_out,
    input  busy, done, data_out
  );

  modport slave (
    input  start, data_in, count_out,
    output busy, done, data_out
  );
endinterface
`default_nettype wire

// File: rtl/inv_mix_col_seq.sv
`default_nettype none
// +------------------------------------------------------------------+
// | inv_mix_col_seq : iterative AES InvMixColumns, one column / clock   |
// | Revision 1.0                                                       |
// +------------------------------------------------------------------+
module inv_mix_col_seq #(
  parameter logic [3:0] BYPASS_ROUND = 4'd9
) (
  input  logic             clk,
  input  logic             rst,
  inv_mix_col_seq_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state, state_next;
  logic [1:0]   col_idx, col_idx_next;
  logic [127:0] work_buf, work_buf_next;
  logic [127:0] result, result_next;
  logic [127:0] data_out_r;
  logic         load_out;
  logic [31:0]  col_in, col_out;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Row r of the output uses coefficients rotated right by r: {0e,0b,0d,09}.
  function automatic logic [31:0] inv_col(input logic [31:0] c);
    logic [7:0] a  [4];
    logic [7:0] m2 [4];
    logic [7:0] m4 [4];
    logic [7:0] m8 [4];
    logic [7:0] k9 [4];
    logic [7:0] kb [4];
    logic [7:0] kd [4];
    logic [7:0] ke [4];
    for (int i = 0; i < 4; i++) begin
      a[i]  = c[31-8*i -: 8];
      m2[i] = xtime(a[i]);
      m4[i] = xtime(m2[i]);
      m8[i] = xtime(m4[i]);
      k9[i] = m8[i] ^ a[i];
      kb[i] = m8[i] ^ m2[i] ^ a[i];
      kd[i] = m8[i] ^ m4[i] ^ a[i];
      ke[i] = m8[i] ^ m4[i] ^ m2[i];
    end
    return {ke[0] ^ kb[1] ^ kd[2] ^ k9[3],
            k9[0] ^ ke[1] ^ kb[2] ^ kd[3],
            kd[0] ^ k9[1] ^ ke[2] ^ kb[3],
            kb[0] ^ kd[1] ^ k9[2] ^ ke[3]};
  endfunction

  assign col_in  = work_buf[{col_idx, 5'd0} +: 32];
  assign col_out = inv_col(col_in);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      col_idx    <= 2'd0;
      work_buf   <= '0;
      result     <= '0;
      data_out_r <= '0;
    end else begin
      state    <= state_next;
      col_idx  <= col_idx_next;
      work_buf <= work_buf_next;
      result   <= result_next;
      if (load_out) data_out_r <= result_next;
    end
  end

  always_comb begin
    state_next    = state;
    col_idx_next  = col_idx;
    work_buf_next = work_buf;
    result_next   = result;
    load_out      = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          work_buf_next = bus.data_in;
          if (bus.count_out == BYPASS_ROUND) begin
            result_next = bus.data_in;
            state_next  = DONE;
            load_out    = 1'b1;
          end else begin
            result_next  = '0;
            col_idx_next = 2'd0;
            state_next   = CALC;
          end
        end else begin
          state_next = IDLE;
        end
      end
      CALC: begin
        result_next[{col_idx, 5'd0} +: 32] = col_out;
        col_idx_next = col_idx + 2'd1;
        if (col_idx == 2'd3) begin
          state_next = DONE;
          load_out   = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.busy     = (state == CALC);
  assign bus.done     = (state == DONE);
  assign bus.data_out = data_out_r;

endmodule
`default_nettype wire

// File: tb/tb_inv_mix_col_seq.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_inv_mix_col_seq : directed and round-trip bench                 |
// | Revision 1.0                                                       |
// +------------------------------------------------------------------+
module tb_inv_mix_col_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  inv_mix_col_seq_if bus ();
  inv_mix_col_seq #(.BYPASS_ROUND(4'd9)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  localparam logic [127:0] VEC_IN  = {32'hc6c6c6c6, 32'h01010101, 32'h9fdc589d, 32'h8e4da1bc};
  localparam logic [127:0] VEC_OUT = {32'hc6c6c6c6, 32'h01010101, 32'hf20a225c, 32'hdb135345};
  localparam logic [127:0] D5_IN   = {4{32'hd5d5d7d6}};
  localparam logic [127:0] D5_OUT  = {4{32'hd4d4d4d5}};
  localparam logic [127:0] F8_IN   = {4{32'h4d7ebdf8}};
  localparam logic [127:0] F8_OUT  = {4{32'h2d26314c}};
  localparam logic [127:0] BYP_IN  = 128'h00112233_44556677_8899aabb_ccddeeff;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Encrypt-side MixColumns, used to build round-trip inputs.
  function automatic logic [127:0] fwd_mix(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      {a0, a1, a2, a3} = s[32*c +: 32];
      r[32*c +: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                       a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                       a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                       xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    end
    return r;
  endfunction

  task automatic run_op(input logic [127:0] d, input logic [3:0] cnt,
                        output logic [127:0] res, output int lat, output int busy_cyc);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.data_in = d; bus.count_out = cnt;
    lat = 0; busy_cyc = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (i == 1) bus.start = 1'b0;
      if (bus.busy) busy_cyc++;
      if (bus.done) begin lat = i; break; end
    end
    res = bus.data_out;
  endtask

  task automatic test_reset();
    #2;
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    n_vec++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", bus.done); end
    n_vec++; if (bus.data_out !== 128'h0) begin n_err++; $display("FAIL reset_data got %h want 0", bus.data_out); end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_known();
    logic [127:0] res; int lat, bc;
    run_op(VEC_IN, 4'd3, res, lat, bc);
    n_vec++; if (res !== VEC_OUT) begin n_err++; $display("FAIL known_data got %h want %h", res, VEC_OUT); end
    n_vec++; if (lat !== 5) begin n_err++; $display("FAIL known_latency got %0d want 5", lat); end
    n_vec++; if (bc !== 4) begin n_err++; $display("FAIL known_busy got %0d want 4", bc); end
    @(posedge clk); #1;
    n_vec++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL done_width got %b want 0", bus.done); end
  endtask

  task automatic test_patterns();
    logic [127:0] res; int lat, bc;
    run_op(D5_IN, 4'd0, res, lat, bc);
    n_vec++; if (res !== D5_OUT) begin n_err++; $display("FAIL pat_d5 got %h want %h", res, D5_OUT); end
    run_op(F8_IN, 4'd1, res, lat, bc);
    n_vec++; if (res !== F8_OUT) begin n_err++; $display("FAIL pat_f8 got %h want %h", res, F8_OUT); end
    run_op(D5_IN, 4'd15, res, lat, bc);
    n_vec++; if (res !== D5_OUT || lat !== 5) begin n_err++; $display("FAIL pat_cnt15 got %h lat %0d want %h lat 5", res, lat, D5_OUT); end
    run_op(F8_IN, 4'd8, res, lat, bc);
    n_vec++; if (res !== F8_OUT || lat !== 5) begin n_err++; $display("FAIL pat_cnt8 got %h lat %0d want %h lat 5", res, lat, F8_OUT); end
  endtask

  task automatic test_bypass();
    logic [127:0] res; int lat, bc;
    run_op(BYP_IN, 4'd9, res, lat, bc);
    n_vec++; if (res !== BYP_IN) begin n_err++; $display("FAIL bypass_data got %h want %h", res, BYP_IN); end
    n_vec++; if (lat !== 1) begin n_err++; $display("FAIL bypass_latency got %0d want 1", lat); end
    n_vec++; if (bc !== 0) begin n_err++; $display("FAIL bypass_busy got %0d want 0", bc); end
  endtask

  task automatic test_back_to_back();
    int t1, t2; bit held_ok, early_done;
    t1 = 0; t2 = 0; held_ok = 1'b1; early_done = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.data_in = VEC_IN; bus.count_out = 4'd2;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      if (i == 1 || i == 6) begin bus.data_in = ~F8_IN; bus.count_out = 4'd9; end
      if (i == 4) begin bus.data_in = D5_IN; bus.count_out = 4'd0; end
      if (i == 9) bus.start = 1'b0;
      if (i >= 6 && i <= 9 && bus.data_out !== VEC_OUT) held_ok = 1'b0;
      if (bus.done) begin
        if (i == 5) t1 = i;
        else if (i == 10) t2 = i;
        else early_done = 1'b1;
        if (i == 5) begin
          n_vec++; if (bus.data_out !== VEC_OUT) begin n_err++; $display("FAIL b2b_first got %h want %h", bus.data_out, VEC_OUT); end
        end
        if (i == 10) begin
          n_vec++; if (bus.data_out !== D5_OUT) begin n_err++; $display("FAIL b2b_second got %h want %h", bus.data_out, D5_OUT); end
        end
      end
    end
    n_vec++; if (t1 !== 5 || t2 !== 10) begin n_err++; $display("FAIL b2b_timing got %0d,%0d want 5,10", t1, t2); end
    n_vec++; if (early_done !== 1'b0) begin n_err++; $display("FAIL b2b_stray_done got %b want 0", early_done); end
    n_vec++; if (held_ok !== 1'b1) begin n_err++; $display("FAIL b2b_hold got %b want 1", held_ok); end
  endtask

  task automatic test_reset_mid();
    logic [127:0] res; int lat, bc; bit saw_done;
    saw_done = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.data_in = F8_IN; bus.count_out = 4'd4;
    @(posedge clk); #1; bus.start = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1; #1;
    n_vec++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin n_err++; $display("FAIL midrst_ctrl got busy %b done %b want 0 0", bus.busy, bus.done); end
    n_vec++; if (bus.data_out !== 128'h0) begin n_err++; $display("FAIL midrst_data got %h want 0", bus.data_out); end
    @(posedge clk); #1; rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (bus.done) saw_done = 1'b1;
    end
    n_vec++; if (saw_done !== 1'b0) begin n_err++; $display("FAIL midrst_no_done got %b want 0", saw_done); end
    run_op(VEC_IN, 4'd5, res, lat, bc);
    n_vec++; if (res !== VEC_OUT || lat !== 5) begin n_err++; $display("FAIL midrst_after got %h lat %0d want %h lat 5", res, lat, VEC_OUT); end
  endtask

  task automatic test_round_trip();
    logic [127:0] orig, res; logic [3:0] cnt; int lat, bc;
    for (int k = 0; k < 1000; k++) begin
      orig = {$urandom, $urandom, $urandom, $urandom};
      cnt  = 4'($urandom_range(0, 14));
      if (cnt == 4'd9) cnt = 4'd15;
      run_op(fwd_mix(orig), cnt, res, lat, bc);
      n_vec++;
      if (res !== orig || lat !== 5) begin
        n_err++; $display("FAIL round_trip[%0d] got %h lat %0d want %h lat 5", k, res, lat, orig);
      end
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.data_in = '0; bus.count_out = '0;
    test_reset();
    test_known();
    test_patterns();
    test_bypass();
    test_back_to_back();
    test_reset_mid();
    test_round_trip();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/inv_mix_col_seq.md
Name: inv_mix_col_seq

Overview:
- Iterative AES InvMixColumns unit for the decryption datapath. It is the inverse of the encrypt-side column mixer.
- Processes the 128-bit state one 32-bit column per clock, using a start/busy/done handshake.
- Sits between inverse AddRoundKey and the next inverse round in the decrypt round loop.
- In the final decrypt round (count_out == 9) it bypasses the state unchanged, matching the encrypt-side skip in the last round.

Parameters:
- BYPASS_ROUND, 4'd9: round count at which the state passes through unmodified.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only when busy=0.
- data_in  input  128  state; column c = data_in[32c+31:32c]; row 0 = MSB byte of the column.
- count_out  input  4  decrypt round counter, sampled with start.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse; data_out is valid.
- data_out  output  128  result; same packing as data_in; held until the next completion.

Behaviour:
- Reset: asynchronous and active-high. Applies to every register.
  - Values: state=IDLE, busy=0, done=0, data_out=0, column index=0, work buffer=0.
  - Reset mid-operation aborts the operation: no done pulse, data_out returns to 0.
- States: IDLE, CALC, DONE.
- IDLE:
  - When start=1, latch data_in into the buffer and clear the result register.
  - If count_out==BYPASS_ROUND, go to DONE with result=data_in.
  - Otherwise set col_idx=0 and go to CALC.
- CALC:
  - busy=1. Each cycle, compute column col_idx from the buffer and write it into the result slot for col_idx. Then increment col_idx.
  - Leave CALC when col_idx==3: the column is written and the state goes to DONE.
  - start is ignored. data_in and count_out may change freely.
- DONE:
  - done=1 and busy=0 for exactly one cycle. data_out is registered from the result on entry to DONE, so it is valid while done=1.
  - A start in DONE is accepted exactly as in IDLE (back-to-back operation). Otherwise go to IDLE.
- Latency, counted from the start-sampling edge E0:
  - Normal: CALC occupies edges E1..E4. done is high in the cycle after E4. Throughput is one result per 5 cycles.
  - Bypass: done is high in the cycle after E0.
- Column math, for column a0..a3 (row0..row3) in GF(2^8) with polynomial x^8+x^4+x^3+x+1 (0x11B):
  - b0 = 0e·a0 ^ 0b·a1 ^ 0d·a2 ^ 09·a3
  - b1 = 09·a0 ^ 0e·a1 ^ 0b·a2 ^ 0d·a3
  - b2 = 0d·a0 ^ 09·a1 ^ 0e·a2 ^ 0b·a3
  - b3 = 0b·a0 ^ 0d·a1 ^ 09·a2 ^ 0e·a3
  - Implementation: a single shared column datapath built from xtime chains (x2, x4, x8); all results are 8-bit. There are no multipliers.
- count_out values other than BYPASS_ROUND all select full InvMixColumns; 10..15 are not special-cased.
- data_out changes only on entry to DONE, never during CALC.

Test Plan:
- Reset, then start with data_in = four columns {8e4da1bc, 9fdc589d, 01010101, c6c6c6c6}, column 0 first, count_out=3 -> done pulses in the 5th cycle after the start edge. data_out columns = {db135345, f20a225c, 01010101, c6c6c6c6}. busy high for 4 cycles.
- All columns d5d5d7d6, count_out=0 -> every data_out column = d4d4d4d5. Then all columns 4d7ebdf8 -> every column = 2d26314c.
- Bypass: count_out=9, data_in=0x00112233_44556677_8899aabb_ccddeeff -> done in the cycle after the start edge. data_out equals data_in bit-exact; busy stays 0.
- Start held high continuously across two operations with different data -> the second start is accepted in the DONE cycle and done pulses 5 cycles apart. Starts during CALC are ignored, and data_in changes during CALC do not alter the result.
- Assert rst during the CALC cycle at col_idx=2 -> outputs are 0 immediately with no done pulse. After release, a fresh start produces the correct result.
- Round-trip: random 128-bit states passed through the encrypt-side mixer, then through this block with count_out≠9 -> the original state is recovered (1000 iterations).
